perf_uart_reporter: RTL and testbench
=====================================

PERF_UART_REPORTER -- requirements
Module: perf_uart_reporter

Interface
REQ-001 Parameter: ClkDiv, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 trigger  input  1  report request; rising edge starts a report.
REQ-005 cnt_cycle  input  32  cycle counter value.
REQ-006 cnt_jump  input  32  jump counter value.
REQ-007 cnt_branch  input  32  branch counter value.
REQ-008 cnt_branched  input  32  taken-branch counter value.
REQ-009 tx  output  1  UART transmit line, 8N1, idle high.
REQ-010 busy  output  1  high while a report is in progress.
REQ-011 done  output  1  one-cycle pulse at report completion.

Function
REQ-012 Edge detect: registered trig_q; a start condition at edge k is trigger=1 and trig_q=0 while state IDLE.
REQ-013 On start, all four counters SHALL be snapshotted in that same edge; later counter changes do not affect the report.
REQ-014 A report SHALL be 44 bytes: four lines of label, 8 hex digits, CR (0x0D), LF (0x0A).
REQ-015 Line order and labels: 'C' (0x43) cnt_cycle, 'J' (0x4A) cnt_jump, 'B' (0x42) cnt_branch, 'T' (0x54) cnt_branched.
REQ-016 Hex digits SHALL be most-significant nibble first; 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-017 Byte framing: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly ClkDiv cycles.
REQ-018 Bytes SHALL be back-to-back with no idle gap; report length exactly 440*ClkDiv cycles.
REQ-019 FSM states IDLE, START, DATA, STOP; IDLE->START on start condition; START->DATA after ClkDiv cycles; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->IDLE.
REQ-020 tx SHALL drive the start bit from the cycle after edge k (latency 1), and busy SHALL rise in that same cycle.
REQ-021 On STOP->IDLE, busy SHALL fall and done SHALL pulse high for exactly one cycle in the same cycle.
REQ-022 Rising edges of trigger while busy SHALL be ignored, not queued.
REQ-023 A start condition on the same edge as STOP->IDLE SHALL be ignored; trigger must see a new rising edge.
REQ-024 The bit-period counter SHALL be sized ceil(log2(ClkDiv)) bits; it reloads at every bit boundary, with no drift across 440 bits.
REQ-025 tx, busy and done SHALL be registered outputs (glitch-free).

Reset
REQ-026 rst asserted: state IDLE; tx=1, busy=0, done=0; bit, byte and period counters=0; snapshot=0; applies immediately (asynchronous), including mid-byte.
REQ-027 trig_q SHALL reset to 1, so a trigger held high through reset release does not start a report.
REQ-028 After rst deasserts, no report SHALL start until trigger goes low and then high again.

Verification (ClkDiv=4)
REQ-029 Counters C=0x0000002A, J=0x1, B=0xDEADBEEF, T=0; pulse trigger -> UART decode yields "C0000002A\r\nJ00000001\r\nBDEADBEEF\r\nT00000000\r\n"; busy high for 1760 cycles; done pulses once.
REQ-030 Change all counters to 0xFFFFFFFF one cycle after the trigger edge -> report still shows the snapshotted values.
REQ-031 Pulse trigger again at cycle 500 of a report -> no effect; exactly 44 bytes; one done pulse.
REQ-032 Assert rst at cycle 123 of a report (mid-byte) -> tx=1 and busy=0 in the same cycle, with no done pulse; hold trigger high through release -> no report; drop trigger, raise it -> full report.
REQ-033 Check bit timing -> every tx transition lands on a multiple of 4 cycles from the first start-bit edge; the first start bit begins 1 cycle after the trigger edge.

Source files
------------

// File: rtl/perf_uart_reporter.sv
// Performance-counter UART reporter: on a trigger rising edge, snapshots four
// 32-bit counters and prints them as four "L%08X\r\n" lines over 8N1 UART.
// Ports: clk, rst (async, active-high), trigger, cnt_cycle, cnt_jump,
//   cnt_branch, cnt_branched (32b each) in; tx (idle high), busy, done out.
module perf_uart_reporter #(
   parameter int ClkDiv = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic [31:0] cnt_cycle,
   input  logic [31:0] cnt_jump,
   input  logic [31:0] cnt_branch,
   input  logic [31:0] cnt_branched,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam logic [CW-1:0] LastP = CW'(ClkDiv - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           r_state;
   logic             r_trig_q;
   logic [3:0][31:0] r_snap;
   logic [CW-1:0]    r_period;
   logic [2:0]       r_bit;
   logic [1:0]       r_line;
   logic [3:0]       r_pos;
   logic [7:0]       r_shift;

   logic        w_start;
   logic        w_pend;
   logic        w_last;
   logic [31:0] w_word;
   logic [2:0]  w_nidx;
   logic [3:0]  w_nib;
   logic [7:0]  w_hex;
   logic [7:0]  w_label;
   logic [7:0]  w_cur;

   assign w_start = (r_state == IDLE) && trigger && !r_trig_q;
   assign w_pend  = (r_period == LastP);
   assign w_last  = (r_line == 2'd3) && (r_pos == 4'd10);

   // Byte to send is derived from the snapshot and the line/position
   // counters; line positions 1..8 map to nibbles 7..0 (MS nibble first).
   always_comb begin
      w_word  = r_snap[r_line];
      w_nidx  = 3'(4'd8 - r_pos);
      w_nib   = w_word[{w_nidx, 2'b00} +: 4];
      w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                : (8'h37 + {4'h0, w_nib});
      w_label = 8'h43;
      unique case (r_line)
         2'd0: w_label = 8'h43;
         2'd1: w_label = 8'h4A;
         2'd2: w_label = 8'h42;
         2'd3: w_label = 8'h54;
      endcase
      w_cur = w_hex;
      if (r_pos == 4'd0)       w_cur = w_label;
      else if (r_pos == 4'd9)  w_cur = 8'h0D;
      else if (r_pos == 4'd10) w_cur = 8'h0A;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_trig_q <= 1'b1;
         r_snap   <= '0;
         r_period <= '0;
         r_bit    <= '0;
         r_line   <= '0;
         r_pos    <= '0;
         r_shift  <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         r_trig_q <= trigger;
         done     <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_snap   <= {cnt_branched, cnt_branch,
                               cnt_jump, cnt_cycle};
                  r_state  <= START;
                  r_period <= '0;
                  r_line   <= '0;
                  r_pos    <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (w_pend) begin
                  r_period <= '0;
                  r_bit    <= '0;
                  r_state  <= DATA;
                  tx       <= w_cur[0];
                  r_shift  <= {1'b0, w_cur[7:1]};
               end else begin
                  r_period <= r_period + 1'b1;
               end
            end
            DATA: begin
               if (w_pend) begin
                  r_period <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     tx      <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_period <= r_period + 1'b1;
               end
            end
            STOP: begin
               if (w_pend) begin
                  r_period <= '0;
                  if (w_last) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     r_state <= START;
                     tx      <= 1'b0;
                     if (r_pos == 4'd10) begin
                        r_pos  <= '0;
                        r_line <= r_line + 1'b1;
                     end else begin
                        r_pos <= r_pos + 1'b1;
                     end
                  end
               end else begin
                  r_period <= r_period + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_uart_reporter.sv
// Self-checking bench for perf_uart_reporter with ClkDiv=4: a UART monitor
// decodes tx into a receive log, checked against a queue of expected bytes.
module tb_perf_uart_reporter;

   localparam int Div = 4;
   localparam int RepCycles = 440 * Div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trigger = 1'b0;
   logic [31:0] cnt_cycle = '0;
   logic [31:0] cnt_jump = '0;
   logic [31:0] cnt_branch = '0;
   logic [31:0] cnt_branched = '0;
   logic        tx;
   logic        busy;
   logic        done;

   perf_uart_reporter #(.ClkDiv(Div)) dut (
      .clk          (clk),
      .rst          (rst),
      .trigger      (trigger),
      .cnt_cycle    (cnt_cycle),
      .cnt_jump     (cnt_jump),
      .cnt_branch   (cnt_branch),
      .cnt_branched (cnt_branched),
      .tx           (tx),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART monitor: decodes frames sampled mid-bit, logs framing and
   // bit-boundary timing errors relative to the first start-bit edge.
   logic [7:0] rx_q[$];
   int         frame_err = 0;
   int         timing_err = 0;
   logic       mon_act = 1'b0;
   int         mcnt = 0;
   logic [7:0] msh = '0;
   logic       prev_tx = 1'b1;
   logic       prev_busy = 1'b0;
   int         base = 0;

   always @(negedge clk) begin
      prev_tx   <= tx;
      prev_busy <= busy;
      if (busy && !prev_busy) base <= cyc;
      if (!rst && busy && (tx != prev_tx)) begin
         if ((((busy && !prev_busy) ? cyc : base) - cyc) % Div != 0)
            timing_err <= timing_err + 1;
      end
      if (rst) begin
         mon_act <= 1'b0;
      end else if (!mon_act) begin
         if (tx == 1'b0) begin
            mon_act <= 1'b1;
            mcnt    <= 1;
         end
      end else begin
         mcnt <= mcnt + 1;
         if (mcnt == 1 && tx != 1'b0) frame_err <= frame_err + 1;
         if (mcnt >= 5 && mcnt <= 33 && (mcnt - 1) % Div == 0)
            msh[(mcnt - 5) / Div] <= tx;
         if (mcnt == 37) begin
            if (tx != 1'b1) frame_err <= frame_err + 1;
            rx_q.push_back(msh);
         end
         if (mcnt == 39) mon_act <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] expv);
      n_checks++;
      assert (got === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
   endfunction

   task automatic push_line(input logic [7:0] lab, input logic [31:0] v);
      logic [31:0] t;
      t = v;
      exp_q.push_back(lab);
      for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(t[i*4 +: 4]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic push_report(input logic [31:0] c, j, b, t);
      push_line(8'h43, c);
      push_line(8'h4A, j);
      push_line(8'h42, b);
      push_line(8'h54, t);
   endtask

   // Fires a trigger pulse and watches a fixed window covering the report.
   // retrig_at: busy-cycle index at which a second trigger edge is raised.
   task automatic run_report(input string tag, input int retrig_at,
                             input bit hold, input bit clobber);
      int busy_n;
      int done_n;
      int fall_done;
      bit seen_fall;
      int rx0;
      int ferr0;
      int terr0;
      rx0 = rx_q.size();
      ferr0 = frame_err;
      terr0 = timing_err;
      busy_n = 0;
      done_n = 0;
      fall_done = 0;
      seen_fall = 1'b0;
      @(negedge clk) trigger = 1'b1;
      @(negedge clk);
      chk({tag, " start tx"}, 32'(tx), 32'd0);
      chk({tag, " start busy"}, 32'(busy), 32'd1);
      if (clobber) begin
         cnt_cycle    = '1;
         cnt_jump     = '1;
         cnt_branch   = '1;
         cnt_branched = '1;
      end
      busy_n = 1;
      trigger = 1'b0;
      for (int i = 0; i < RepCycles + 40; i++) begin
         @(negedge clk);
         if (done) done_n++;
         if (busy) busy_n++;
         if (!busy && !seen_fall) begin
            seen_fall = 1'b1;
            fall_done = int'(done);
         end
         if (busy && busy_n == retrig_at) trigger = 1'b1;
         else if (!hold) trigger = 1'b0;
      end
      trigger = 1'b0;
      chk({tag, " busy cycles"}, busy_n, RepCycles);
      chk({tag, " done pulses"}, done_n, 1);
      chk({tag, " done at busy fall"}, fall_done, 1);
      chk({tag, " byte count"}, rx_q.size() - rx0, 44);
      for (int i = 0; i < 44; i++) begin
         logic [7:0] e;
         logic [7:0] g;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         g = (rx0 + i < rx_q.size()) ? rx_q[rx0 + i] : 8'hzz;
         chk($sformatf("%s byte %0d", tag, i), 32'(g), 32'(e));
      end
      exp_q.delete();
      chk({tag, " framing"}, frame_err - ferr0, 0);
      chk({tag, " bit timing"}, timing_err - terr0, 0);
   endtask

   initial begin
      int b_n;
      int d_n;
      int rx0;
      repeat (3) @(negedge clk);
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);

      cnt_cycle    = 32'h0000002A;
      cnt_jump     = 32'h00000001;
      cnt_branch   = 32'hDEADBEEF;
      cnt_branched = 32'h00000000;
      push_report(cnt_cycle, cnt_jump, cnt_branch, cnt_branched);
      run_report("basic", 0, 1'b0, 1'b0);

      cnt_cycle    = 32'h12345678;
      cnt_jump     = 32'h9ABCDEF0;
      cnt_branch   = 32'h0F0F0F0F;
      cnt_branched = 32'hA5A5A5A5;
      push_report(cnt_cycle, cnt_jump, cnt_branch, cnt_branched);
      run_report("snapshot", 0, 1'b0, 1'b1);

      cnt_cycle    = 32'h00000100;
      cnt_jump     = 32'h00000020;
      cnt_branch   = 32'h00000003;
      cnt_branched = 32'h80000000;
      push_report(cnt_cycle, cnt_jump, cnt_branch, cnt_branched);
      run_report("retrig", 500, 1'b0, 1'b0);

      // Rising edge on the very cycle the report ends, then held high.
      push_report(cnt_cycle, cnt_jump, cnt_branch, cnt_branched);
      run_report("end edge", RepCycles, 1'b1, 1'b0);

      // Mid-byte asynchronous reset with trigger held through release.
      @(negedge clk) trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      repeat (122) @(negedge clk);
      rst = 1'b1;
      trigger = 1'b1;
      #1;
      chk("async rst tx", 32'(tx), 32'd1);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rx0 = rx_q.size();
      b_n = 0;
      d_n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) b_n++;
         if (done) d_n++;
      end
      chk("held trig busy", b_n, 0);
      chk("held trig done", d_n, 0);
      chk("held trig bytes", rx_q.size() - rx0, 0);
      trigger = 1'b0;
      repeat (2) @(negedge clk);
      cnt_cycle    = 32'hCAFEF00D;
      cnt_jump     = 32'h00C0FFEE;
      cnt_branch   = 32'h7FFFFFFF;
      cnt_branched = 32'h00000009;
      push_report(cnt_cycle, cnt_jump, cnt_branch, cnt_branched);
      run_report("after rst", 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
